// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Bundles the decoded-field input stream (valid/ready) and the
//               instruction-memory write port used by instr_encoder_loader.
//               master : the host/boot side. It drives the field bundle and
//                        the memory acceptance strobe.
//               slave  : the encoder/loader. It accepts bundles and issues
//                        memory writes.
//               Signals:
//                 in_valid_i/in_ready_o/in_last_i  stream handshake
//                 op_code_i, rd_i, rs1_i, rs2_i,
//                 funct3_i, fnc7_h20_i, imm_i      decoded instruction fields
//                 imem_wr_en_o/imem_addr_o/
//                 imem_data_o/imem_ready_i         memory write port
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_last_i;
    logic [6:0]  op_code_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic        fnc7_h20_i;
    logic [31:0] imm_i;
    logic        imem_wr_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_o;
    logic        imem_ready_i;

    modport master (
        output in_valid_i, in_last_i, op_code_i, rd_i, rs1_i, rs2_i,
               funct3_i, fnc7_h20_i, imm_i, imem_ready_i,
        input  in_ready_o, imem_wr_en_o, imem_addr_o, imem_data_o
    );

    modport slave (
        input  in_valid_i, in_last_i, op_code_i, rd_i, rs1_i, rs2_i,
               funct3_i, fnc7_h20_i, imm_i, imem_ready_i,
        output in_ready_o, imem_wr_en_o, imem_addr_o, imem_data_o
    );
endinterface : instr_encoder_loader_if
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Packs decoded RV32I instruction fields (R/I/S/B/U/J formats)
//               into 32-bit words. Each word is written sequentially into
//               instruction memory through a single-entry write buffer with
//               backpressure. A session starts on start_i. It ends after the
//               bundle marked last, or on overflow. done_o pulses once at the
//               end of the session.
// Ports       : clk_i, rst_i (async, active-high), start_i
//               bus     - instr_encoder_loader_if.slave (stream + imem port)
//               busy_o  - high while loading or flushing
//               done_o  - one-cycle end-of-session pulse
//               count_o - words written in the current/last session
//               err_o   - sticky: [0] illegal opcode, [1] immediate range,
//                         [2] overflow
// Options     : ENC_IMM_CHK_EN - when defined, immediates are range-checked.
//               An out-of-range legal bundle is dropped and sets err_o[1].
//               When undefined, immediates are truncated to the field width.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    instr_encoder_loader_if.slave bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [2:0]            err_o
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_LAST_IDX  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_LOAD  = 2'd1,
        c_FLUSH = 2'd2,
        c_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_wr_pend;
    logic [31:0]      r_data;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_err;

    logic [31:0]      w_word;
    logic             w_legal;
    logic             w_is_shift;
    logic             w_imm_ok;
    logic [6:0]       w_f7;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_complete;
    logic [CNT_W-1:0] w_occupancy;
    logic             w_full;
    logic             w_write;
    logic             w_ovf;

    // ------------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------------
    assign w_f7       = {1'b0, bus.fnc7_h20_i, 5'b00000};
    assign w_is_shift = (bus.op_code_i == c_OP_IMM) &&
                        ((bus.funct3_i == 3'd1) || (bus.funct3_i == 3'd5));

    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b1;
        case (bus.op_code_i)
            c_OP_R: begin
                w_word = {w_f7, bus.rs2_i, bus.rs1_i, bus.funct3_i,
                          bus.rd_i, bus.op_code_i};
            end
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
                if (w_is_shift) begin
                    // Shift-immediates carry shamt plus the SRAI select bit.
                    w_word = {w_f7, bus.imm_i[4:0], bus.rs1_i, bus.funct3_i,
                              bus.rd_i, bus.op_code_i};
                end else begin
                    w_word = {bus.imm_i[11:0], bus.rs1_i,
                              (bus.op_code_i == c_OP_JALR) ? 3'b000 : bus.funct3_i,
                              bus.rd_i, bus.op_code_i};
                end
            end
            c_OP_STORE: begin
                w_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                          bus.imm_i[4:0], bus.op_code_i};
            end
            c_OP_BRANCH: begin
                w_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i,
                          bus.funct3_i, bus.imm_i[4:1], bus.imm_i[11],
                          bus.op_code_i};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_word = {bus.imm_i[31:12], bus.rd_i, bus.op_code_i};
            end
            c_OP_JAL: begin
                w_word = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11],
                          bus.imm_i[19:12], bus.rd_i, bus.op_code_i};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Immediate range check
    // ------------------------------------------------------------------------
`ifdef ENC_IMM_CHK_EN
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    // A value fits a signed N-bit field when all bits above N-1 match bit N-1.
    assign w_fits12 = (&bus.imm_i[31:11]) || !(|bus.imm_i[31:11]);
    assign w_fits13 = (&bus.imm_i[31:12]) || !(|bus.imm_i[31:12]);
    assign w_fits21 = (&bus.imm_i[31:20]) || !(|bus.imm_i[31:20]);

    always_comb begin
        w_imm_ok = 1'b1;
        case (bus.op_code_i)
            c_OP_IMM:                          w_imm_ok = w_is_shift ? (bus.imm_i[31:5] == 27'd0)
                                                                     : w_fits12;
            c_OP_LOAD, c_OP_JALR, c_OP_STORE: w_imm_ok = w_fits12;
            c_OP_BRANCH:                       w_imm_ok = w_fits13 && !bus.imm_i[0];
            c_OP_LUI, c_OP_AUIPC:              w_imm_ok = (bus.imm_i[11:0] == 12'd0);
            c_OP_JAL:                          w_imm_ok = w_fits21 && !bus.imm_i[0];
            default:                           w_imm_ok = 1'b1;
        endcase
    end
`else
    assign w_imm_ok = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Handshake and write-buffer control
    // ------------------------------------------------------------------------
    // A new bundle may enter while the buffered write retires this same cycle.
    assign w_in_ready  = (r_state == c_LOAD) && (!r_wr_pend || bus.imem_ready_i);
    assign w_accept    = bus.in_valid_i && w_in_ready;
    assign w_complete  = r_wr_pend && bus.imem_ready_i;

    // Words already written plus the one still buffered.
    assign w_occupancy = r_count + CNT_W'(r_wr_pend);
    assign w_full      = (w_occupancy == c_DEPTH_CNT);
    assign w_write     = w_accept && w_legal && w_imm_ok && !w_full;
    assign w_ovf       = w_accept && w_legal && w_imm_ok && w_full;

    // ------------------------------------------------------------------------
    // Session FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_nxt = c_LOAD;
                end
            end
            c_LOAD: begin
                busy_o = 1'b1;
                if (w_accept && (bus.in_last_i || w_ovf)) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                busy_o = 1'b1;
                if (!r_wr_pend) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: write buffer, address, count, sticky errors
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_pend <= 1'b0;
            r_data    <= 32'h0000_0000;
            r_addr    <= BASE_ADDR;
            r_count   <= '0;
            r_err     <= 3'b000;
        end else if ((r_state == c_IDLE) && start_i) begin
            r_count <= '0;
            r_err   <= 3'b000;
            r_addr  <= BASE_ADDR;
        end else begin
            if (w_complete) begin
                r_count <= r_count + c_CNT_ONE;
                // The address stops at the last slot, so it never points
                // beyond the window even after a full session.
                if (r_count != c_LAST_IDX) begin
                    r_addr <= r_addr + 32'd4;
                end
            end

            if (w_write) begin
                r_wr_pend <= 1'b1;
                r_data    <= w_word;
            end else if (w_complete) begin
                r_wr_pend <= 1'b0;
            end

            if (w_accept && !w_legal) begin
                r_err[0] <= 1'b1;
            end
            if (w_accept && w_legal && !w_imm_ok) begin
                r_err[1] <= 1'b1;
            end
            if (w_ovf) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o   = w_in_ready;
    assign bus.imem_wr_en_o = r_wr_pend;
    assign bus.imem_addr_o  = r_addr;
    assign bus.imem_data_o  = r_data;
    assign count_o          = r_count;
    assign err_o            = r_err;

endmodule : instr_encoder_loader
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench. dut0 uses the default parameters.
//               dut1 uses a non-zero base address and DEPTH=4. Directed
//               vectors are checked against literal expected words. Random
//               sessions are checked against a field-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE0  = 32'h0000_0000;
    localparam int          DEPTH0 = 1024;
    localparam int          CW0    = $clog2(DEPTH0) + 1;
    localparam logic [31:0] BASE1  = 32'h0000_1000;
    localparam int          DEPTH1 = 4;
    localparam int          CW1    = $clog2(DEPTH1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start0 = 1'b0, start1 = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [CW0-1:0] count0;
    logic [CW1-1:0] count1;
    logic [2:0] err0, err1;

    // Stimulus driven by the bench
    logic        sel     = 1'b0;
    logic        t_valid = 1'b0, t_last = 1'b0, t_f7 = 1'b0;
    logic [6:0]  t_op    = '0;
    logic [4:0]  t_rd    = '0, t_rs1 = '0, t_rs2 = '0;
    logic [2:0]  t_f3    = '0;
    logic [31:0] t_imm   = '0;
    logic        imem_ready = 1'b1;

    instr_encoder_loader_if if0 ();
    instr_encoder_loader_if if1 ();

    assign if0.in_valid_i = t_valid && !sel;
    assign if1.in_valid_i = t_valid && sel;
    assign if0.in_last_i = t_last;   assign if1.in_last_i = t_last;
    assign if0.op_code_i = t_op;     assign if1.op_code_i = t_op;
    assign if0.rd_i      = t_rd;     assign if1.rd_i      = t_rd;
    assign if0.rs1_i     = t_rs1;    assign if1.rs1_i     = t_rs1;
    assign if0.rs2_i     = t_rs2;    assign if1.rs2_i     = t_rs2;
    assign if0.funct3_i  = t_f3;     assign if1.funct3_i  = t_f3;
    assign if0.fnc7_h20_i = t_f7;    assign if1.fnc7_h20_i = t_f7;
    assign if0.imm_i     = t_imm;    assign if1.imm_i     = t_imm;
    assign if0.imem_ready_i = imem_ready;
    assign if1.imem_ready_i = imem_ready;

    instr_encoder_loader #(.BASE_ADDR(BASE0), .DEPTH(DEPTH0), .CNT_W(CW0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .bus(if0),
        .busy_o(busy0), .done_o(done0), .count_o(count0), .err_o(err0)
    );

    instr_encoder_loader #(.BASE_ADDR(BASE1), .DEPTH(DEPTH1), .CNT_W(CW1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .bus(if1),
        .busy_o(busy1), .done_o(done1), .count_o(count1), .err_o(err1)
    );

    wire w_ready = sel ? if1.in_ready_o : if0.in_ready_o;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory-side acceptance: random, forced-stall window, or held low
    // ------------------------------------------------------------------------
    int cyc = 0;
    int stall_until = 0;
    bit rdy_rand = 1'b0;
    bit ready_low = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (ready_low || cyc < stall_until) imem_ready = 1'b0;
        else if (rdy_rand)                  imem_ready = ($urandom_range(0, 3) != 0);
        else                                imem_ready = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Reference model: expected writes per DUT as {addr, data}
    // ------------------------------------------------------------------------
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          m_n;
    logic [2:0]  m_err;
    bit          m_end;
    int          m_depth;
    logic [31:0] m_base;

    always @(negedge clk) begin
        if (!rst && if0.imem_wr_en_o) begin
            check_eq("d0_wr_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                check_eq("d0_wr_addr", if0.imem_addr_o, q0[0][63:32]);
                check_eq("d0_wr_data", if0.imem_data_o, q0[0][31:0]);
                if (!imem_ready) check_eq("d0_in_ready_stalled", if0.in_ready_o, 0);
                else             void'(q0.pop_front());
            end
        end
        if (!rst && if1.imem_wr_en_o) begin
            check_eq("d1_wr_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                check_eq("d1_wr_addr", if1.imem_addr_o, q1[0][63:32]);
                check_eq("d1_wr_data", if1.imem_data_o, q1[0][31:0]);
                if (!imem_ready) check_eq("d1_in_ready_stalled", if1.in_ready_o, 0);
                else             void'(q1.pop_front());
            end
        end
    end

    function automatic bit m_legal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    endfunction

    function automatic bit m_imm_ok(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
`ifdef ENC_IMM_CHK_EN
        int s;
        s = signed'(imm);
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return imm <= 32'd31;
        if (op inside {7'h13, 7'h03, 7'h67, 7'h23}) return (s >= -2048) && (s <= 2047);
        if (op == 7'h63) return (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
        if (op == 7'h6F) return (s >= -1048576) && (s <= 1048575) && (imm % 2 == 0);
        if (op inside {7'h37, 7'h17}) return (imm % 4096) == 0;
        return 1'b1;
`else
        return (op == op) && (f3 == f3) && (imm == imm);
`endif
    endfunction

    // Word built from the field positions by shifting and masking.
    function automatic logic [31:0] m_word(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                           input logic [2:0] f3, input logic f7, input logic [31:0] imm);
        logic [31:0] base_rr, f7v;
        f7v     = f7 ? 32'h4000_0000 : 32'h0;
        base_rr = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (op)
            7'h33: return base_rr | (32'(rd) << 7) | (32'(rs2) << 20) | f7v;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
                    return base_rr | (32'(rd) << 7) | ((imm % 32) << 20) | f7v;
                if (op == 7'h67) base_rr = 32'(op) | (32'(rs1) << 15);
                return base_rr | (32'(rd) << 7) | ((imm % 4096) << 20);
            end
            7'h23: return base_rr | (32'(rs2) << 20) | ((imm % 32) << 7) | (((imm >> 5) % 128) << 25);
            7'h63: return base_rr | (32'(rs2) << 20) | (((imm >> 11) % 2) << 7) |
                          (((imm >> 1) % 16) << 8) | (((imm >> 5) % 64) << 25) | (((imm >> 12) % 2) << 31);
            7'h37, 7'h17: return 32'(op) | (32'(rd) << 7) | ((imm >> 12) << 12);
            7'h6F: return 32'(op) | (32'(rd) << 7) | (((imm >> 12) % 256) << 12) |
                          (((imm >> 11) % 2) << 20) | (((imm >> 1) % 1024) << 21) | (((imm >> 20) % 2) << 31);
            default: return 32'h0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------------
    task automatic begin_session(input bit s);
        sel = s; m_n = 0; m_err = 3'b000; m_end = 1'b0;
        m_depth = s ? DEPTH1 : DEPTH0;
        m_base  = s ? BASE1 : BASE0;
        @(posedge clk); #1;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                        input logic f7, input logic [31:0] imm, input bit last,
                        input bit use_lit, input logic [31:0] lit);
        bit hs = 1'b0;
        logic [63:0] e;
        if (m_end) return;
        if (rdy_rand) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        t_op = op; t_rd = rd; t_rs1 = rs1; t_rs2 = rs2; t_f3 = f3; t_f7 = f7; t_imm = imm;
        t_last = last; t_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (w_ready) begin hs = 1'b1; break; end
        end
        check_eq("handshake", hs, 1);
        @(posedge clk); #1;
        t_valid = 1'b0;
        if (!hs) begin m_end = 1'b1; return; end
        if (!m_legal(op)) m_err[0] = 1'b1;
        else if (!m_imm_ok(op, f3, imm)) m_err[1] = 1'b1;
        else if (m_n == m_depth) begin m_err[2] = 1'b1; m_end = 1'b1; end
        else begin
            e = {m_base + 32'(4 * m_n), use_lit ? lit : m_word(op, rd, rs1, rs2, f3, f7, imm)};
            if (sel) q1.push_back(e); else q0.push_back(e);
            m_n++;
        end
        if (last) m_end = 1'b1;
    endtask

    task automatic end_session();
        bit seen = 1'b0;
        int  idx;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sel ? done1 : done0) begin seen = 1'b1; break; end
        end
        check_eq("done_pulse", seen, 1);
        if (seen) begin
            idx = (m_n < m_depth - 1) ? m_n : m_depth - 1;
            check_eq("count", sel ? 64'(count1) : 64'(count0), m_n);
            check_eq("err", sel ? err1 : err0, m_err);
            check_eq("final_addr", sel ? if1.imem_addr_o : if0.imem_addr_o, m_base + 32'(4 * idx));
            check_eq("writes_drained", sel ? q1.size() : q0.size(), 0);
            check_eq("busy_at_done", sel ? busy1 : busy0, 0);
            @(negedge clk);
            check_eq("done_one_cycle", sel ? done1 : done0, 0);
        end
    endtask

    task automatic send_rand(input bit last);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        int k;
        k   = $urandom_range(0, 9);
        f3  = 3'($urandom);
        imm = $urandom;
        case (k)
            0: op = 7'h33;
            1, 2: begin
                op = 7'h13;
                if (k == 2) f3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'($urandom_range(0, 31))
                                                  : 32'($urandom_range(0, 4095)) - 32'd2048;
            end
            3: begin op = 7'h03; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            4: begin op = 7'h67; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            5: begin op = 7'h23; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            6: begin op = 7'h63; imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
            7: begin op = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17; imm = imm & 32'hFFFF_F000; end
            8: begin op = 7'h6F; imm = (32'($urandom_range(0, 1048575)) - 32'h8_0000) << 1; end
            default: begin
                op = 7'($urandom);
                while (m_legal(op)) op = 7'($urandom);
            end
        endcase
        if ($urandom_range(0, 7) == 0) imm = $urandom;
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), f3, 1'($urandom), imm, last, 1'b0, 32'h0);
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_en", if0.imem_wr_en_o, 0);
        check_eq("rst_addr0", if0.imem_addr_o, BASE0);
        check_eq("rst_addr1", if1.imem_addr_o, BASE1);
        check_eq("rst_data", if0.imem_data_o, 0);
        check_eq("rst_in_ready", if0.in_ready_o, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_count", count0, 0);
        check_eq("rst_err", err0, 0);
        rst = 1'b0;

        // Single ADD
        begin_session(1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h002081B3);
        end_session();

        // Mixed-format stream
        begin_session(1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,          1'b0, 1'b1, 32'h402081B3);
        send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd8,          1'b0, 1'b1, 32'h00512423);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC,  1'b0, 1'b1, 32'hFE000EE3);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,       1'b0, 1'b1, 32'h001000EF);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000,  1'b0, 1'b1, 32'h123452B7);
        send(7'h13, 5'd4, 5'd4, 5'd0, 3'd5, 1'b1, 32'd3,          1'b1, 1'b1, 32'h40325213);
        end_session();

        // Memory stall of five cycles on the second write
        begin_session(1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, 1'b1, 32'h402081B3);
        stall_until = cyc + 6;
        send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd8, 1'b0, 1'b1, 32'h00512423);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b1, 1'b1, 32'h123452B7);
        end_session();

        // Illegal opcode mid-stream
        begin_session(1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b1, 1'b1, 32'h402081B3);
        end_session();

        // Overflow on the DEPTH=4 instance
        begin_session(1'b1);
        for (int i = 0; i < 5; i++)
            send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, i == 4, 1'b1, 32'h002081B3);
        end_session();

        // ADDI with an immediate too wide for the field
        begin_session(1'b0);
        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd4096, 1'b1, 1'b1, 32'h00010093);
        end_session();

        // Reset in the middle of a session with a write outstanding
        ready_low = 1'b1;
        @(posedge clk); #1;
        begin_session(1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_wr_en", if0.imem_wr_en_o, 0);
        check_eq("midrst_addr", if0.imem_addr_o, BASE0);
        check_eq("midrst_count", count0, 0);
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_in_ready", if0.in_ready_o, 0);
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ready_low = 1'b0;

        // Randomized sessions on both instances
        rdy_rand = 1'b1;
        for (int s = 0; s < 10; s++) begin
            int len;
            begin_session(s >= 6);
            len = (s >= 6) ? $urandom_range(2, 7) : $urandom_range(5, 25);
            for (int i = 0; i < len; i++) send_rand(i == len - 1);
            end_session();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_instr_encoder_loader
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Reverse of the opcode/funct decode path: takes decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I words (R/I/S/B/U/J formats).
- Writes each packed word sequentially into instruction memory through a write port with backpressure.
- Sits between the debug/boot host interface and the instruction memory; runs before the core is released from reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written in each load session.
- DEPTH, 1024, maximum number of words per session; must be a power of two.
- CNT_W, $clog2(DEPTH)+1, width of the word counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  begins a load session; honoured only in IDLE.
- in_valid_i  in  1  field bundle valid.
- in_ready_o  out  1  field bundle accepted when both valid and ready are high.
- in_last_i  in  1  marks the final instruction of the session.
- op_code_i  in  7  opcode.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3  funct3.
- fnc7_h20_i  in  1  funct7 bit 5 (SUB/SRA/SRAI select).
- imm_i  in  32  immediate as a sign-extended byte offset or value; for U-type, bits [31:12] are used.
- imem_wr_en_o  out  1  write request.
- imem_addr_o  out  32  byte address.
- imem_data_o  out  32  encoded word.
- imem_ready_i  in  1  memory accepts the write this cycle.
- busy_o  out  1  high in LOAD or FLUSH.
- done_o  out  1  one-cycle pulse at session end.
- count_o  out  CNT_W  words written in the current/last session.
- err_o  out  3  sticky flags: [0] illegal opcode, [1] immediate range, [2] overflow.

Behaviour:
- Reset: all outputs 0; state IDLE; imem_addr_o = BASE_ADDR.
- State IDLE:
  - in_ready_o = 0.
  - start_i -> LOAD; count, err and address are reset to 0/0/BASE_ADDR on that edge.
- State LOAD:
  - in_ready_o = !wr_pend || imem_ready_i.
  - start_i is ignored.
  - A handshake with in_last_i = 1 -> FLUSH.
- State FLUSH:
  - in_ready_o = 0.
  - Moves to DONE once no write is pending.
- State DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - count_o and err_o hold until the next start_i.
- Write latency:
  - An input accepted at cycle N produces imem_wr_en_o = 1 with the registered word and address at N+1.
  - The request holds, stable, until imem_ready_i is high.
  - Back-to-back inputs give one write per cycle when imem_ready_i stays high.
- Address and count:
  - After each completed write, address += 4 and count += 1.
- Encoding (unlisted bits = 0):
  - R-type (0110011): funct7 = {0, fnc7_h20_i, 00000}.
  - I-type (0010011, 0000011, 1100111): imm[11:0].
    - For 0010011 with funct3 = 1 or 5: word[31:25] = {0, fnc7_h20_i, 00000}, word[24:20] = imm_i[4:0].
    - JALR forces funct3 = 0.
  - S-type (0100011): imm[11:5] into [31:25], imm[4:0] into [11:7].
  - B-type (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U-type (0110111, 0010111): {imm[31:12], rd, op}.
  - J-type (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Illegal opcode (any other value):
  - The bundle is accepted but no write is issued and count is unchanged.
  - err_o[0] is set.
  - in_last_i on such a bundle still moves to FLUSH.
- Overflow:
  - A legal bundle accepted when count + pending = DEPTH is dropped, err_o[2] is set, and the state moves to FLUSH.
  - The address never exceeds BASE_ADDR + 4*(DEPTH-1).
- Reset mid-session: the pending write is abandoned immediately; all state returns to reset values.

Optional Feature:
- ENC_IMM_CHK_EN defined: the immediate is range-checked. A failing legal bundle is handled like an illegal opcode, but sets err_o[1]. Limits:
  - I/S: signed 12-bit.
  - Shifts: 0..31.
  - B: signed 13-bit, even.
  - J: signed 21-bit, even.
  - U: imm_i[11:0] = 0.
- ENC_IMM_CHK_EN undefined: the immediate is silently truncated to the field; err_o[1] is tied to 0.

Test Plan:
- start, then ADD x3,x1,x2 with last, imem_ready_i = 1 -> one write: data 0x002081B3, addr BASE_ADDR; done_o pulses; count_o = 1.
- Stream SUB x3,x1,x2; SW x5,8(x2); BEQ x0,x0,-4; JAL x1,2048; LUI x5,0x12345; SRAI x4,x4,3 (last) -> writes 0x402081B3, 0x00512423, 0xFE000EE3, 0x001000EF, 0x123452B7, 0x40325213 at consecutive +4 addresses; count_o = 6.
- Hold imem_ready_i = 0 for 5 cycles during the 2nd write -> data/address stable, in_ready_o = 0, no bundle lost; sequence completes in order.
- Opcode 7'h7F mid-stream -> no write for it, err_o[0] = 1, later addresses contiguous.
- DEPTH = 4, 5 legal bundles -> 4 writes, err_o[2] = 1, done_o pulses.
- With ENC_IMM_CHK_EN defined, ADDI imm = 4096 -> no write, err_o[1] = 1. Without it -> word 0x00000013 | rd/rs1 fields, err_o = 0.
